// File: rtl/systolic_tile_engine_pkg.sv
// tile_engine_pkg: state encoding and arithmetic helpers shared by the systolic tile engine
package tile_engine_pkg;
  typedef enum logic [2:0] {IDLE, FEED, FLUSH, DRAIN, DONE} state_e;
  function automatic int flush_len(input int rows, input int cols);
    return rows + cols - 1;
  endfunction
  // Sign- or zero-extend a pw-bit product held in the low bits of p
  function automatic logic [63:0] ext_prod(input logic [63:0] p, input int pw, input logic sgn);
    logic [63:0] m;
    m = {64{1'b1}} << pw;
    return (sgn && p[pw-1]) ? (p | m) : (p & ~m);
  endfunction
endpackage

// File: rtl/systolic_tile_engine_if.sv
// systolic_tile_engine_if: control, operand stream and result drain bundle
interface systolic_tile_engine_if #(
  parameter int WIDTH = 8,
  parameter int ACCUMULATOR_WIDTH = 32,
  parameter int ROWS = 4,
  parameter int COLS = 4,
  parameter int K_MAX = 256
);
  logic Start;
  logic [$clog2(K_MAX+1)-1:0] K_Len;
  logic Accumulate;
  logic Signed_Mode;
  logic In_Valid;
  logic In_Ready;
  logic [WIDTH-1:0] Inputs [ROWS];
  logic [WIDTH-1:0] Weights [COLS];
  logic Out_Valid;
  logic Out_Ready;
  logic [$clog2(ROWS)-1:0] Out_Row;
  logic [ACCUMULATOR_WIDTH-1:0] Result [COLS];
  logic Busy;
  logic Done;
  modport master(
    output Start, K_Len, Accumulate, Signed_Mode, In_Valid, Inputs, Weights, Out_Ready,
    input In_Ready, Out_Valid, Out_Row, Result, Busy, Done
  );
  modport slave(
    input Start, K_Len, Accumulate, Signed_Mode, In_Valid, Inputs, Weights, Out_Ready,
    output In_Ready, Out_Valid, Out_Row, Result, Busy, Done
  );
endinterface

// File: rtl/systolic_tile_engine_pe.sv
// tile_pe: output-stationary MAC cell; operands are forwarded right/down one step later
module tile_pe import tile_engine_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int ACCUMULATOR_WIDTH = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic clr_i,
  input  logic clr_acc_i,
  input  logic sgn_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] a_o,
  output logic [WIDTH-1:0] b_o,
  output logic [ACCUMULATOR_WIDTH-1:0] acc_o
);
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [ACCUMULATOR_WIDTH-1:0] acc_q, acc_d, prod_x;
  logic [2*WIDTH-1:0] ax, bx, prod;
  always_comb begin
    ax = sgn_i ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
    bx = sgn_i ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
    prod = ax * bx;
    prod_x = ACCUMULATOR_WIDTH'(ext_prod(64'(prod), 2*WIDTH, sgn_i));
    a_d = clr_i ? '0 : en_i ? a_i : a_q;
    b_d = clr_i ? '0 : en_i ? b_i : b_q;
    acc_d = clr_acc_i ? '0 : en_i ? acc_q + prod_x : acc_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q <= '0;
      b_q <= '0;
      acc_q <= '0;
    end else begin
      a_q <= a_d;
      b_q <= b_d;
      acc_q <= acc_d;
    end
  end
  assign a_o = a_q;
  assign b_o = b_q;
  assign acc_o = acc_q;
endmodule

// File: rtl/systolic_tile_engine.sv
// systolic_tile_engine: ROWS x COLS output-stationary matmul with operand skew, flush and row drain
module systolic_tile_engine import tile_engine_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int ACCUMULATOR_WIDTH = 32,
  parameter int ROWS = 4,
  parameter int COLS = 4,
  parameter int K_MAX = 256
) (
  input logic CLK,
  input logic SYNC_RST,
  systolic_tile_engine_if.slave bus
);
  localparam int KW = $clog2(K_MAX+1);
  localparam int FL = flush_len(ROWS, COLS);
  localparam int FW = $clog2(FL+1);
  localparam int RW = $clog2(ROWS);
  state_e state_q, state_d;
  logic [KW-1:0] k_len_q, k_len_d, k_cnt_q, k_cnt_d;
  logic [FW-1:0] fl_cnt_q, fl_cnt_d;
  logic [RW-1:0] row_q, row_d;
  logic sgn_q, sgn_d, start_ok, step, clr_acc;
  logic [WIDTH-1:0] a_in [ROWS];
  logic [WIDTH-1:0] b_in [COLS];
  logic [WIDTH-1:0] a_w [ROWS][COLS+1];
  logic [WIDTH-1:0] b_w [ROWS+1][COLS];
  logic [ACCUMULATOR_WIDTH-1:0] acc_w [ROWS][COLS];
  always_comb begin
    state_d = state_q;
    k_len_d = k_len_q;
    k_cnt_d = k_cnt_q;
    fl_cnt_d = fl_cnt_q;
    row_d = row_q;
    sgn_d = sgn_q;
    start_ok = state_q == IDLE && bus.Start;
    step = (state_q == FEED && bus.In_Valid) || state_q == FLUSH;
    clr_acc = start_ok && !bus.Accumulate;
    case (state_q)
      IDLE: if (bus.Start) begin
        state_d = bus.K_Len == '0 ? FLUSH : FEED;
        k_len_d = bus.K_Len;
        k_cnt_d = '0;
        fl_cnt_d = '0;
        sgn_d = bus.Signed_Mode;
      end
      FEED: if (bus.In_Valid) begin
        k_cnt_d = k_cnt_q + KW'(1);
        state_d = k_cnt_d == k_len_q ? FLUSH : FEED;
      end
      FLUSH: begin
        fl_cnt_d = fl_cnt_q + FW'(1);
        state_d = fl_cnt_d == FW'(FL) ? DRAIN : FLUSH;
        row_d = '0;
      end
      DRAIN: if (bus.Out_Ready) begin
        row_d = row_q == RW'(ROWS-1) ? '0 : row_q + RW'(1);
        state_d = row_q == RW'(ROWS-1) ? DONE : DRAIN;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (SYNC_RST) begin
      state_q <= IDLE;
      k_len_q <= '0;
      k_cnt_q <= '0;
      fl_cnt_q <= '0;
      row_q <= '0;
      sgn_q <= 1'b0;
    end else begin
      state_q <= state_d;
      k_len_q <= k_len_d;
      k_cnt_q <= k_cnt_d;
      fl_cnt_q <= fl_cnt_d;
      row_q <= row_d;
      sgn_q <= sgn_d;
    end
  end
  assign bus.In_Ready = state_q == FEED;
  assign bus.Out_Valid = state_q == DRAIN;
  assign bus.Out_Row = row_q;
  assign bus.Busy = state_q != IDLE;
  assign bus.Done = state_q == DONE;
  // Lane r is delayed by r shift stages; flush injects zeros at every lane head
  for (genvar r = 0; r < ROWS; r++) begin : g_a_skew
    assign a_in[r] = state_q == FEED ? bus.Inputs[r] : '0;
    if (r == 0) begin : g_direct
      assign a_w[0][0] = a_in[0];
    end else begin : g_delay
      logic [WIDTH-1:0] sk_q [r];
      always_ff @(posedge CLK) begin
        if (SYNC_RST || start_ok) begin
          for (int i = 0; i < r; i++) sk_q[i] <= '0;
        end else if (step) begin
          sk_q[0] <= a_in[r];
          for (int i = 1; i < r; i++) sk_q[i] <= sk_q[i-1];
        end
      end
      assign a_w[r][0] = sk_q[r-1];
    end
  end
  for (genvar c = 0; c < COLS; c++) begin : g_b_skew
    assign b_in[c] = state_q == FEED ? bus.Weights[c] : '0;
    if (c == 0) begin : g_direct
      assign b_w[0][0] = b_in[0];
    end else begin : g_delay
      logic [WIDTH-1:0] sk_q [c];
      always_ff @(posedge CLK) begin
        if (SYNC_RST || start_ok) begin
          for (int i = 0; i < c; i++) sk_q[i] <= '0;
        end else if (step) begin
          sk_q[0] <= b_in[c];
          for (int i = 1; i < c; i++) sk_q[i] <= sk_q[i-1];
        end
      end
      assign b_w[0][c] = sk_q[c-1];
    end
  end
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      tile_pe #(.WIDTH(WIDTH), .ACCUMULATOR_WIDTH(ACCUMULATOR_WIDTH)) u_pe (
        .clk(CLK),
        .rst(SYNC_RST),
        .en_i(step),
        .clr_i(start_ok),
        .clr_acc_i(clr_acc),
        .sgn_i(sgn_q),
        .a_i(a_w[r][c]),
        .b_i(b_w[r][c]),
        .a_o(a_w[r][c+1]),
        .b_o(b_w[r+1][c]),
        .acc_o(acc_w[r][c])
      );
    end
  end
  for (genvar c = 0; c < COLS; c++) begin : g_drain
    assign bus.Result[c] = state_q == DRAIN ? acc_w[row_q][c] : '0;
  end
endmodule
